// File: rtl/delay_range_checker_rtl.sv
// Multi-channel checker for a |-> ##[MIN_DLY:MAX_DLY] b with overlapping attempts,
// saturating pass/fail event counters and a sticky first-failure capture.
module delay_range_checker_rtl #(
  parameter int NUM_CH  = 1,
  parameter int MIN_DLY = 1,
  parameter int MAX_DLY = 4,
  parameter int CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      clr,
  input  logic [NUM_CH-1:0]         a,
  input  logic [NUM_CH-1:0]         b,
  output logic [NUM_CH-1:0]         assertion_pass,
  output logic [NUM_CH-1:0]         assertion_fail,
  output logic [NUM_CH-1:0]         assertion_active,
  output logic [CNT_W-1:0]          pass_cnt,
  output logic [CNT_W-1:0]          fail_cnt,
  output logic                      fail_seen,
  output logic [$clog2(NUM_CH):0]   first_fail_ch
);

  localparam int FCH_W = $clog2(NUM_CH) + 1;

  generate
    if (MIN_DLY < 1 || MIN_DLY > MAX_DLY || MAX_DLY > 64 || NUM_CH < 1 || NUM_CH > 32) begin : g_bad_param
      $error("delay_range_checker_rtl: illegal NUM_CH/MIN_DLY/MAX_DLY");
    end
  endgenerate

  logic [NUM_CH-1:0] w_pass_now;
  logic [NUM_CH-1:0] w_fail_now;
  logic [NUM_CH-1:0] w_active_next;
  logic [FCH_W-1:0]  w_first_idx;

  logic [NUM_CH-1:0] r_pass;
  logic [NUM_CH-1:0] r_fail;
  logic [NUM_CH-1:0] r_active;
  logic [CNT_W-1:0]  r_pass_cnt;
  logic [CNT_W-1:0]  r_fail_cnt;
  logic              r_fail_seen;
  logic [FCH_W-1:0]  r_first_fail_ch;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      // r_p[j] = attempt launched j samples ago is still pending
      logic [MAX_DLY:1] r_p;
      logic [MAX_DLY:1] w_p_next;

      always_comb begin
        w_p_next    = '0;
        w_p_next[1] = a[gi] & en;
        for (int j = 1; j < MAX_DLY; j++) begin
          w_p_next[j+1] = r_p[j] & ~(b[gi] & (j >= MIN_DLY));
        end
      end

      assign w_pass_now[gi]    = b[gi] & (|r_p[MAX_DLY:MIN_DLY]);
      assign w_fail_now[gi]    = r_p[MAX_DLY] & ~b[gi];
      assign w_active_next[gi] = |w_p_next;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_p <= '0;
        end else begin
          r_p <= w_p_next;
        end
      end
    end
  endgenerate

  // Descending scan so the lowest failing channel wins.
  always_comb begin
    w_first_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (w_fail_now[i]) begin
        w_first_idx = FCH_W'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pass   <= '0;
      r_fail   <= '0;
      r_active <= '0;
    end else begin
      r_pass   <= w_pass_now;
      r_fail   <= w_fail_now;
      r_active <= w_active_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pass_cnt      <= '0;
      r_fail_cnt      <= '0;
      r_fail_seen     <= 1'b0;
      r_first_fail_ch <= '0;
    end else if (clr) begin
      r_pass_cnt      <= '0;
      r_fail_cnt      <= '0;
      r_fail_seen     <= 1'b0;
      r_first_fail_ch <= '0;
    end else begin
      if ((|w_pass_now) && (r_pass_cnt != {CNT_W{1'b1}})) begin
        r_pass_cnt <= r_pass_cnt + CNT_W'(1);
      end
      if ((|w_fail_now) && (r_fail_cnt != {CNT_W{1'b1}})) begin
        r_fail_cnt <= r_fail_cnt + CNT_W'(1);
      end
      if (!r_fail_seen && (|w_fail_now)) begin
        r_fail_seen     <= 1'b1;
        r_first_fail_ch <= w_first_idx;
      end
    end
  end

  assign assertion_pass   = r_pass;
  assign assertion_fail   = r_fail;
  assign assertion_active = r_active;
  assign pass_cnt         = r_pass_cnt;
  assign fail_cnt         = r_fail_cnt;
  assign fail_seen        = r_fail_seen;
  assign first_fail_ch    = r_first_fail_ch;

endmodule
